sprite_draw_scheduler: RTL and testbench

SPRITE_DRAW_SCHEDULER -- requirements
Module: sprite_draw_scheduler

---
 rtl/sprite_draw_scheduler.sv | 177 +++++++++++++++++
 tb/tb_sprite_draw_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sprite_draw_scheduler
// Purpose  : Pops sprite jobs from a draw queue and issues them round-robin
//            to NUM_LANES render lanes, framing the work between a
//            frame_start pulse and a frame_done pulse.
// Options  : SPRITE_SCHED_STATS_EN builds the per-frame issue counter and
//            the sticky frame-overrun flag; otherwise both outputs read 0.
// Revision : 1.0  initial release
// ============================================================================
module sprite_draw_scheduler #(
  parameter int NUM_LANES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic                 q_empty,
  output logic                 q_dequeue,
  input  logic [7:0]           q_sprite_id,
  input  logic [15:0]          q_sprite_x,
  input  logic [15:0]          q_sprite_y,
  input  logic [7:0]           q_sprite_scale,
  output logic [NUM_LANES-1:0] lane_start,
  input  logic [NUM_LANES-1:0] lane_done,
  output logic [7:0]           job_id,
  output logic [15:0]          job_x,
  output logic [15:0]          job_y,
  output logic [7:0]           job_scale,
  output logic [NUM_LANES-1:0] lane_busy,
  output logic                 frame_active,
  output logic                 frame_done,
  output logic [15:0]          sprites_issued,
  output logic                 frame_overrun
);

  localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [PTR_W-1:0] LAST_RESET = PTR_W'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [PTR_W-1:0] last_lane;   // lane that received the most recent job
  logic [PTR_W-1:0] sel_lane;    // lane chosen in SCAN, pulsed in ISSUE
  logic [PTR_W-1:0] pick_lane;
  logic             pick_valid;
  logic [PTR_W:0]   cand;        // one extra bit so last+k cannot wrap

  // Round-robin search: first free lane after last_lane, wrapping once.
  always_comb begin
    pick_valid = 1'b0;
    pick_lane  = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      cand = {1'b0, last_lane} + (PTR_W + 1)'(k);
      if (cand >= (PTR_W + 1)'(NUM_LANES)) begin
        cand = cand - (PTR_W + 1)'(NUM_LANES);
      end
      if (!pick_valid && !lane_busy[cand[PTR_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_lane  = cand[PTR_W-1:0];
      end
    end
  end

  // Next-state decode and the combinational handshake/pulse outputs.
  always_comb begin
    state_next = state;
    q_dequeue  = 1'b0;
    frame_done = 1'b0;
    lane_start = '0;
    case (state)
      S_IDLE: begin
        if (frame_start) begin
          state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        // Eligibility uses the registered busy flags, so a lane_done seen
        // in this cycle only frees the lane for the next decision.
        if (!q_empty && pick_valid) begin
          q_dequeue  = 1'b1;
          state_next = S_ISSUE;
        end else if (q_empty && (lane_busy == '0)) begin
          state_next = S_DONE;
        end
      end
      S_ISSUE: begin
        lane_start[sel_lane] = 1'b1;
        state_next           = S_SCAN;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Lane busy tracking, frame window, job latch and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      lane_busy    <= '0;
      frame_active <= 1'b0;
      job_id       <= '0;
      job_x        <= '0;
      job_y        <= '0;
      job_scale    <= '0;
      sel_lane     <= '0;
      last_lane    <= LAST_RESET;
    end else begin
      // A lane being issued is never busy, so its own done cannot collide.
      lane_busy <= (lane_busy & ~lane_done) | lane_start;
      if ((state == S_IDLE) && frame_start) begin
        frame_active <= 1'b1;
      end else if (state == S_DONE) begin
        frame_active <= 1'b0;
      end
      if (q_dequeue) begin
        job_id    <= q_sprite_id;
        job_x     <= q_sprite_x;
        job_y     <= q_sprite_y;
        job_scale <= q_sprite_scale;
        sel_lane  <= pick_lane;
      end
      if (state == S_ISSUE) begin
        last_lane <= sel_lane;
      end
    end
  end

`ifdef SPRITE_SCHED_STATS_EN
  logic [15:0] issued_count;
  logic        overrun_flag;

  // Per-frame issue counter (saturating) and sticky overrun flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      issued_count <= '0;
      overrun_flag <= 1'b0;
    end else begin
      if ((state == S_IDLE) && frame_start) begin
        issued_count <= '0;
      end else if ((lane_start != '0) && (issued_count != 16'hFFFF)) begin
        issued_count <= issued_count + 16'd1;
      end
      if (frame_start && (state != S_IDLE)) begin
        overrun_flag <= 1'b1;
      end
    end
  end

  assign sprites_issued = issued_count;
  assign frame_overrun  = overrun_flag;
`else
  assign sprites_issued = 16'd0;
  assign frame_overrun  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sprite_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_draw_scheduler
// Purpose  : Table-driven and scripted checks of sprite_draw_scheduler with a
//            queue emulator and a job scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sprite_draw_scheduler;

  localparam int N = 2;
`ifdef SPRITE_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          q_empty;
  logic          q_dequeue;
  logic [7:0]    q_sprite_id;
  logic [15:0]   q_sprite_x;
  logic [15:0]   q_sprite_y;
  logic [7:0]    q_sprite_scale;
  logic [N-1:0]  lane_start;
  logic [N-1:0]  lane_done;
  logic [7:0]    job_id;
  logic [15:0]   job_x;
  logic [15:0]   job_y;
  logic [7:0]    job_scale;
  logic [N-1:0]  lane_busy;
  logic          frame_active;
  logic          frame_done;
  logic [15:0]   sprites_issued;
  logic          frame_overrun;

  sprite_draw_scheduler #(.NUM_LANES(N)) dut (
    .clock          (clock),
    .reset          (reset),
    .frame_start    (frame_start),
    .q_empty        (q_empty),
    .q_dequeue      (q_dequeue),
    .q_sprite_id    (q_sprite_id),
    .q_sprite_x     (q_sprite_x),
    .q_sprite_y     (q_sprite_y),
    .q_sprite_scale (q_sprite_scale),
    .lane_start     (lane_start),
    .lane_done      (lane_done),
    .job_id         (job_id),
    .job_x          (job_x),
    .job_y          (job_y),
    .job_scale      (job_scale),
    .lane_busy      (lane_busy),
    .frame_active   (frame_active),
    .frame_done     (frame_done),
    .sprites_issued (sprites_issued),
    .frame_overrun  (frame_overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  scale;
  } sprite_t;

  typedef struct {
    sprite_t s;
    int      lane;
  } exp_t;

  typedef struct {
    int         load;
    logic       fs;
    logic [N-1:0] done;
    logic       deq;
    logic [N-1:0] ls;
    logic [N-1:0] busy;
    logic       fa;
    logic       fd;
  } vec_t;

  sprite_t      tbq[$];
  exp_t         sb[$];
  vec_t         vq[$];
  logic [N-1:0] model_busy;
  logic [N-1:0] mod_issue;
  int           model_last;
  int           next_id;
  int           checks;
  int           passed;
  logic         s_fd, s_deq, s_fa;
  logic [N-1:0] s_ls, s_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] busy);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (!busy[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic refresh_head();
    q_empty = (tbq.size() == 0);
    if (tbq.size() > 0) begin
      q_sprite_id    = tbq[0].id;
      q_sprite_x     = tbq[0].x;
      q_sprite_y     = tbq[0].y;
      q_sprite_scale = tbq[0].scale;
    end else begin
      q_sprite_id    = '0;
      q_sprite_x     = '0;
      q_sprite_y     = '0;
      q_sprite_scale = '0;
    end
  endtask

  task automatic push_sprites(input int n);
    for (int i = 0; i < n; i++) begin
      sprite_t s;
      s.id    = 8'(next_id);
      s.x     = 16'h1000 + 16'(next_id * 3);
      s.y     = 16'h2000 + 16'(next_id * 5);
      s.scale = 8'h80 ^ 8'(next_id);
      tbq.push_back(s);
      next_id++;
    end
    refresh_head();
  endtask

  task automatic add_vec(input int load, input logic fs, input logic [N-1:0] done,
                         input logic deq, input logic [N-1:0] ls, input logic [N-1:0] busy,
                         input logic fa, input logic fd);
    vec_t v;
    v.load = load; v.fs = fs; v.done = done; v.deq = deq;
    v.ls = ls; v.busy = busy; v.fa = fa; v.fd = fd;
    vq.push_back(v);
  endtask

  // Per-cycle scoreboard: issues must follow dequeues one cycle later.
  task automatic sample_cycle();
    s_fd   = frame_done;
    s_deq  = q_dequeue;
    s_ls   = lane_start;
    s_fa   = frame_active;
    s_busy = lane_busy;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("lane_start", 32'(lane_start), 32'(1 << e.lane));
      chk("job_id", 32'(job_id), 32'(e.s.id));
      chk("job_x", 32'(job_x), 32'(e.s.x));
      chk("job_y", 32'(job_y), 32'(e.s.y));
      chk("job_scale", 32'(job_scale), 32'(e.s.scale));
      mod_issue  = N'(1 << e.lane);
      model_last = e.lane;
    end else begin
      chk("no_lane_start", 32'(lane_start), 32'd0);
    end
    if (q_dequeue) begin
      int pick;
      chk("deq_not_empty", 32'(tbq.size() > 0), 32'd1);
      pick = rr_pick(model_last, model_busy);
      chk("deq_lane_free", 32'(pick >= 0), 32'd1);
      if (pick >= 0 && tbq.size() > 0) begin
        exp_t e;
        e.s = tbq[0];
        e.lane = pick;
        sb.push_back(e);
      end
    end
    chk("lane_busy", 32'(lane_busy), 32'(model_busy));
  endtask

  task automatic tick(input logic fs, input logic [N-1:0] done, input logic rst);
    reset       = rst;
    frame_start = fs;
    lane_done   = done;
    @(negedge clock);
    sample_cycle();
    @(posedge clock);
    #1;
    if (s_deq && tbq.size() > 0) tbq.delete(0);
    if (rst) begin
      model_busy = '0;
      model_last = N - 1;
      sb.delete();
    end else begin
      model_busy = (model_busy & ~done) | mod_issue;
    end
    mod_issue   = '0;
    frame_start = 1'b0;
    lane_done   = '0;
    refresh_head();
  endtask

  task automatic check_reset_vals();
    chk("rst_q_dequeue", 32'(q_dequeue), 32'd0);
    chk("rst_lane_start", 32'(lane_start), 32'd0);
    chk("rst_lane_busy", 32'(lane_busy), 32'd0);
    chk("rst_frame_active", 32'(frame_active), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_job", {job_id, job_scale, job_x}, 32'd0);
    chk("rst_job_y", 32'(job_y), 32'd0);
    chk("rst_sprites_issued", 32'(sprites_issued), 32'd0);
    chk("rst_frame_overrun", 32'(frame_overrun), 32'd0);
  endtask

  task automatic run_to_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1'b0, model_busy, 1'b0);
      if (s_fd) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks = 0; passed = 0; next_id = 1;
    model_busy = '0; mod_issue = '0; model_last = N - 1;
    reset = 1'b1; frame_start = 1'b0; lane_done = '0;
    refresh_head();
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    check_reset_vals();
    @(posedge clock);
    #1;

    // Empty frame, then three sprites with lanes held busy until released.
    add_vec(0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    add_vec(0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0);
    add_vec(0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1);
    add_vec(0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    add_vec(3, 1, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    add_vec(0, 0, 2'b00, 1, 2'b00, 2'b00, 1, 0);
    add_vec(0, 0, 2'b00, 0, 2'b01, 2'b00, 1, 0);
    add_vec(0, 0, 2'b00, 1, 2'b00, 2'b01, 1, 0);
    add_vec(0, 0, 2'b00, 0, 2'b10, 2'b01, 1, 0);
    add_vec(0, 0, 2'b00, 0, 2'b00, 2'b11, 1, 0);
    add_vec(0, 0, 2'b01, 0, 2'b00, 2'b11, 1, 0);
    add_vec(0, 0, 2'b00, 1, 2'b00, 2'b10, 1, 0);
    add_vec(0, 0, 2'b00, 0, 2'b01, 2'b10, 1, 0);
    add_vec(0, 0, 2'b11, 0, 2'b00, 2'b11, 1, 0);
    add_vec(0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0);
    add_vec(0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1);
    add_vec(0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].load > 0) push_sprites(vq[i].load);
      tick(vq[i].fs, vq[i].done, 1'b0);
      chk($sformatf("vec%0d_deq", i), 32'(s_deq), 32'(vq[i].deq));
      chk($sformatf("vec%0d_ls", i), 32'(s_ls), 32'(vq[i].ls));
      chk($sformatf("vec%0d_busy", i), 32'(s_busy), 32'(vq[i].busy));
      chk($sformatf("vec%0d_fa", i), 32'(s_fa), 32'(vq[i].fa));
      chk($sformatf("vec%0d_fd", i), 32'(s_fd), 32'(vq[i].fd));
    end
    chk("issued_after_3", 32'(sprites_issued), STATS ? 32'd3 : 32'd0);
    chk("overrun_clean", 32'(frame_overrun), 32'd0);

    // frame_start while scanning: ignored by the FSM, flags an overrun.
    push_sprites(1);
    tick(1'b1, 2'b00, 1'b0);
    tick(1'b1, 2'b00, 1'b0);
    chk("ovr_deq_in_scan", 32'(s_deq), 32'd1);
    run_to_done("ovr_frame_done_seen");
    chk("ovr_flag", 32'(frame_overrun), STATS ? 32'd1 : 32'd0);
    chk("ovr_issued", 32'(sprites_issued), STATS ? 32'd1 : 32'd0);
    tick(1'b1, 2'b00, 1'b0);
    tick(1'b0, 2'b00, 1'b0);
    tick(1'b0, 2'b00, 1'b0);
    chk("empty_frame_done", 32'(s_fd), 32'd1);
    tick(1'b0, 2'b00, 1'b0);
    chk("ovr_sticky", 32'(frame_overrun), STATS ? 32'd1 : 32'd0);

    // Reset while issuing to lane 0 with lane 1 busy.
    tick(1'b0, 2'b00, 1'b1);
    push_sprites(3);
    tick(1'b1, 2'b00, 1'b0);
    tick(1'b0, 2'b00, 1'b0);
    tick(1'b0, 2'b00, 1'b0);
    tick(1'b0, 2'b00, 1'b0);
    tick(1'b0, 2'b00, 1'b0);
    tick(1'b0, 2'b01, 1'b0);
    tick(1'b0, 2'b00, 1'b0);
    tick(1'b0, 2'b00, 1'b1);
    chk("pre_rst_issue", 32'(s_ls), 32'd1);
    chk("pre_rst_busy", 32'(s_busy), 32'd2);
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals();
    @(posedge clock);
    #1;
    push_sprites(1);
    tick(1'b1, 2'b00, 1'b0);
    tick(1'b0, 2'b00, 1'b0);
    tick(1'b0, 2'b00, 1'b0);
    chk("post_rst_lane0", 32'(s_ls), 32'd1);
    run_to_done("post_rst_frame_done");
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
